sap1_ctrl_seq: RTL and testbench

//  Control sequencer for the SAP-1 datapath: a T-state FSM that emits the per-cycle control word
//  (bus drive enables, register load strobes, ALU subtract select, halt) for fetch and execute.

---
 rtl/sap1_ctrl_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_sap1_ctrl_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sap1_ctrl_seq.sv
// sap1_ctrl_seq
//   Control sequencer for the SAP-1 datapath. A T-state machine walks the
//   fetch cycle (T1..T3) and then the execute cycle (T4..T6, or T4..T7 for
//   ADD/SUB) selected by the IR opcode. Each cycle it emits the control word
//   that drives the PC, MAR, RAM, IR, accumulator, B register, add/sub unit
//   and output register.
//
//   ADD and SUB get a seventh T-state. The add/sub unit registers its result
//   in T6, and only in T7 is that result placed on the bus and loaded into
//   the accumulator.
//
// Ports
//   clk_i      clock, all state changes on the rising edge
//   rst_i      synchronous reset, active high, returns the FSM to IDLE
//   run_i      start request, only looked at in IDLE
//   opcode_i   IR opcode field, valid from T4 until the end of the next T3
//   pc_oe_o    Ep  PC drives bus
//   pc_inc_o   Cp  PC increments
//   mar_ld_o   Lm  MAR loads from bus
//   ram_oe_o   CE  RAM drives bus
//   ir_ld_o    Li  IR loads from bus
//   ir_oe_o    Ei  IR operand drives bus
//   acc_ld_o   La  accumulator loads from bus
//   acc_oe_o   Ea  accumulator drives bus
//   b_ld_o     Lb  B register loads from bus
//   sub_en_o   Su  add/sub unit selects subtract
//   alu_oe_o   Eu  add/sub result drives bus
//   out_ld_o   Lo  output register loads from bus
//   hlt_o      high while halted
//   tstate_o   one-hot T1..T7 (bit0 = T1), all zero in IDLE and HALT

module sap1_ctrl_seq #(
  parameter int               OPC_W  = 4,
  parameter logic [OPC_W-1:0] OP_LDA = 4'b0000,
  parameter logic [OPC_W-1:0] OP_ADD = 4'b0001,
  parameter logic [OPC_W-1:0] OP_SUB = 4'b0010,
  parameter logic [OPC_W-1:0] OP_OUT = 4'b1110,
  parameter logic [OPC_W-1:0] OP_HLT = 4'b1111
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic [OPC_W-1:0] opcode_i,
  output logic             pc_oe_o,
  output logic             pc_inc_o,
  output logic             mar_ld_o,
  output logic             ram_oe_o,
  output logic             ir_ld_o,
  output logic             ir_oe_o,
  output logic             acc_ld_o,
  output logic             acc_oe_o,
  output logic             b_ld_o,
  output logic             sub_en_o,
  output logic             alu_oe_o,
  output logic             out_ld_o,
  output logic             hlt_o,
  output logic [6:0]       tstate_o
);

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T1   = 4'd1,
    ST_T2   = 4'd2,
    ST_T3   = 4'd3,
    ST_T4   = 4'd4,
    ST_T5   = 4'd5,
    ST_T6   = 4'd6,
    ST_T7   = 4'd7,
    ST_HALT = 4'd8
  } state_t;

  // Instruction class decoded from the opcode. Unknown opcodes are NOPs.
  typedef enum logic [2:0] {
    INS_NOP,
    INS_LDA,
    INS_ADD,
    INS_SUB,
    INS_OUT,
    INS_HLT
  } instr_t;

  state_t state_q;
  state_t state_d;
  instr_t instrClass;

  // Opcode classification. It is only meaningful from T4 on; fetch states
  // ignore it.
  always_comb begin
    instrClass = INS_NOP;
    if (opcode_i == OP_LDA) begin
      instrClass = INS_LDA;
    end else if (opcode_i == OP_ADD) begin
      instrClass = INS_ADD;
    end else if (opcode_i == OP_SUB) begin
      instrClass = INS_SUB;
    end else if (opcode_i == OP_OUT) begin
      instrClass = INS_OUT;
    end else if (opcode_i == OP_HLT) begin
      instrClass = INS_HLT;
    end
  end

  // Next-state logic. Fetch always runs T1..T3. HLT leaves T4 for HALT.
  // Only the two-operand ALU instructions take the T7 write-back slot.
  // After the first instruction there is no path back to IDLE except
  // through reset.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: state_d = run_i ? ST_T1 : ST_IDLE;
      ST_T1:   state_d = ST_T2;
      ST_T2:   state_d = ST_T3;
      ST_T3:   state_d = ST_T4;
      ST_T4:   state_d = (instrClass == INS_HLT) ? ST_HALT : ST_T5;
      ST_T5:   state_d = ST_T6;
      ST_T6:   state_d = (instrClass == INS_ADD || instrClass == INS_SUB)
                         ? ST_T7 : ST_T1;
      ST_T7:   state_d = ST_T1;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register. Reset has priority over every transition, HALT included.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Control word decode. Every strobe defaults low, so IDLE, HALT and the
  // idle execute slots produce no activity. The arms are written so that at
  // most one bus driver is asserted in any state.
  always_comb begin
    pc_oe_o  = 1'b0;
    pc_inc_o = 1'b0;
    mar_ld_o = 1'b0;
    ram_oe_o = 1'b0;
    ir_ld_o  = 1'b0;
    ir_oe_o  = 1'b0;
    acc_ld_o = 1'b0;
    acc_oe_o = 1'b0;
    b_ld_o   = 1'b0;
    sub_en_o = 1'b0;
    alu_oe_o = 1'b0;
    out_ld_o = 1'b0;
    hlt_o    = 1'b0;
    unique case (state_q)
      ST_T1: begin
        pc_oe_o  = 1'b1;
        mar_ld_o = 1'b1;
      end
      ST_T2: begin
        pc_inc_o = 1'b1;
      end
      ST_T3: begin
        ram_oe_o = 1'b1;
        ir_ld_o  = 1'b1;
      end
      ST_T4: begin
        unique case (instrClass)
          INS_LDA, INS_ADD, INS_SUB: begin
            ir_oe_o  = 1'b1;
            mar_ld_o = 1'b1;
          end
          INS_OUT: begin
            acc_oe_o = 1'b1;
            out_ld_o = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T5: begin
        unique case (instrClass)
          INS_LDA: begin
            ram_oe_o = 1'b1;
            acc_ld_o = 1'b1;
          end
          INS_ADD, INS_SUB: begin
            ram_oe_o = 1'b1;
            b_ld_o   = 1'b1;
          end
          default: ;
        endcase
      end
      // The add/sub unit captures ACC op B here. Only the subtract select
      // matters in this cycle.
      ST_T6: begin
        sub_en_o = (instrClass == INS_SUB);
      end
      // Write-back of the registered ALU result. Subtract select is held so
      // the unit sees a stable mode across both cycles.
      ST_T7: begin
        alu_oe_o = 1'b1;
        acc_ld_o = 1'b1;
        sub_en_o = (instrClass == INS_SUB);
      end
      ST_HALT: begin
        hlt_o = 1'b1;
      end
      default: ;
    endcase
  end

  // One-hot T-state indicator for the front panel and for debug.
  always_comb begin
    tstate_o = 7'b0000000;
    unique case (state_q)
      ST_T1:   tstate_o = 7'b0000001;
      ST_T2:   tstate_o = 7'b0000010;
      ST_T3:   tstate_o = 7'b0000100;
      ST_T4:   tstate_o = 7'b0001000;
      ST_T5:   tstate_o = 7'b0010000;
      ST_T6:   tstate_o = 7'b0100000;
      ST_T7:   tstate_o = 7'b1000000;
      default: tstate_o = 7'b0000000;
    endcase
  end

endmodule

// File: tb/tb_sap1_ctrl_seq.sv
// tb_sap1_ctrl_seq
//   Directed bench for the SAP-1 control sequencer. It steps single
//   instructions and compares the packed control word and tstate_o against
//   hand-written tables in each cycle. A small datapath model (ACC, B, the
//   registered add/sub result) is driven by the DUT strobes, so the
//   arithmetic outcomes are known constants.

module tb_sap1_ctrl_seq;

  logic       clk;
  logic       rstI;
  logic       runI;
  logic [3:0] opcodeI;
  logic pcOe, pcInc, marLd, ramOe, irLd, irOe, accLd, accOe;
  logic bLd, subEn, aluOe, outLd, hlt;
  logic [6:0] tstate;

  sap1_ctrl_seq dut (
    .clk_i    (clk),
    .rst_i    (rstI),
    .run_i    (runI),
    .opcode_i (opcodeI),
    .pc_oe_o  (pcOe),
    .pc_inc_o (pcInc),
    .mar_ld_o (marLd),
    .ram_oe_o (ramOe),
    .ir_ld_o  (irLd),
    .ir_oe_o  (irOe),
    .acc_ld_o (accLd),
    .acc_oe_o (accOe),
    .b_ld_o   (bLd),
    .sub_en_o (subEn),
    .alu_oe_o (aluOe),
    .out_ld_o (outLd),
    .hlt_o    (hlt),
    .tstate_o (tstate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word bit masks, MSB first: Ep Cp Lm CE Li Ei La Ea Lb Su Eu Lo HLT
  localparam logic [12:0] C_PC_OE  = 13'h1000;
  localparam logic [12:0] C_PC_INC = 13'h0800;
  localparam logic [12:0] C_MAR_LD = 13'h0400;
  localparam logic [12:0] C_RAM_OE = 13'h0200;
  localparam logic [12:0] C_IR_LD  = 13'h0100;
  localparam logic [12:0] C_IR_OE  = 13'h0080;
  localparam logic [12:0] C_ACC_LD = 13'h0040;
  localparam logic [12:0] C_ACC_OE = 13'h0020;
  localparam logic [12:0] C_B_LD   = 13'h0010;
  localparam logic [12:0] C_SUB    = 13'h0008;
  localparam logic [12:0] C_ALU_OE = 13'h0004;
  localparam logic [12:0] C_OUT_LD = 13'h0002;
  localparam logic [12:0] C_HLT    = 13'h0001;
  localparam logic [12:0] C_NONE   = 13'h0000;

  // Per-instruction tables. Index 0 is T1 and sits rightmost in the
  // concatenation.
  localparam logic [6:0][12:0] EXP_LDA = {C_NONE, C_NONE,
    C_RAM_OE | C_ACC_LD, C_IR_OE | C_MAR_LD,
    C_RAM_OE | C_IR_LD, C_PC_INC, C_PC_OE | C_MAR_LD};
  localparam logic [6:0][12:0] EXP_ADD = {C_ALU_OE | C_ACC_LD, C_NONE,
    C_RAM_OE | C_B_LD, C_IR_OE | C_MAR_LD,
    C_RAM_OE | C_IR_LD, C_PC_INC, C_PC_OE | C_MAR_LD};
  localparam logic [6:0][12:0] EXP_SUB = {C_ALU_OE | C_ACC_LD | C_SUB, C_SUB,
    C_RAM_OE | C_B_LD, C_IR_OE | C_MAR_LD,
    C_RAM_OE | C_IR_LD, C_PC_INC, C_PC_OE | C_MAR_LD};
  localparam logic [6:0][12:0] EXP_OUT = {C_NONE, C_NONE,
    C_NONE, C_ACC_OE | C_OUT_LD,
    C_RAM_OE | C_IR_LD, C_PC_INC, C_PC_OE | C_MAR_LD};
  localparam logic [6:0][12:0] EXP_NOP = {C_NONE, C_NONE,
    C_NONE, C_NONE,
    C_RAM_OE | C_IR_LD, C_PC_INC, C_PC_OE | C_MAR_LD};

  logic [12:0] ctrlObs;
  assign ctrlObs = {pcOe, pcInc, marLd, ramOe, irLd, irOe, accLd, accOe,
                    bLd, subEn, aluOe, outLd, hlt};

  int assertCount = 0;
  int failCount   = 0;

  // Datapath model. RAM data for the current operand is whatever the bench
  // put in ramData.
  logic [7:0] ramData = 8'h00;
  logic [7:0] accModel = 8'h00;
  logic [7:0] bModel = 8'h00;
  logic [7:0] aluModel = 8'h00;

  // The model updates from the strobes seen at each rising edge, the same
  // way the real registers would.
  always @(posedge clk) begin
    if (accLd && ramOe) accModel <= ramData;
    else if (accLd && aluOe) accModel <= aluModel;
    if (bLd) bModel <= ramData;
    if (tstate[5]) aluModel <= subEn ? (accModel - bModel) : (accModel + bModel);
  end

  // Single comparison point: counts the check and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives the inputs, then advances one clock. Sampling happens 1 ns after
  // the edge, away from it.
  task automatic applyStimulus(input logic r, input logic run, input logic [3:0] opc);
    rstI    = r;
    runI    = run;
    opcodeI = opc;
    @(posedge clk);
    #1;
  endtask

  task automatic checkBus(input string tag);
    checkOutput(tag, 32'($countones({pcOe, ramOe, irOe, accOe, aluOe}) <= 1), 32'd1);
  endtask

  // Steps n cycles of an instruction that must start in T1, checking the
  // control word, the T-state and bus exclusivity in every cycle. run_i is
  // toggled to show it is ignored.
  task automatic runCycles(input string tag, input logic [3:0] opc,
                           input logic [7:0] ram, input int n,
                           input logic [6:0][12:0] expTab);
    ramData = ram;
    opcodeI = opc;
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s ctrl T%0d", tag, i + 1), 32'(ctrlObs), 32'(expTab[i]));
      checkOutput($sformatf("%s tstate T%0d", tag, i + 1), 32'(tstate), 32'(7'(1) << i));
      checkBus($sformatf("%s bus T%0d", tag, i + 1));
      applyStimulus(1'b0, i[0], opc);
    end
  endtask

  initial begin
    rstI    = 1'b1;
    runI    = 1'b0;
    opcodeI = 4'h0;

    // Reset held for three cycles, then idle with run low.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 4'h0);
    checkOutput("reset ctrl", 32'(ctrlObs), 32'(C_NONE));
    checkOutput("reset tstate", 32'(tstate), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 4'h0);
      checkOutput("idle ctrl", 32'(ctrlObs), 32'(C_NONE));
      checkOutput("idle tstate", 32'(tstate), 32'd0);
    end

    // Start: LDA 5, ADD 3 -> ACC = 8
    applyStimulus(1'b0, 1'b1, 4'h0);
    runCycles("LDA5", 4'h0, 8'd5, 6, EXP_LDA);
    checkOutput("acc after LDA5", 32'(accModel), 32'd5);
    runCycles("ADD3", 4'h1, 8'd3, 7, EXP_ADD);
    checkOutput("acc after ADD", 32'(accModel), 32'd8);

    // LDA 9, SUB 4 -> 5. LDA 2, SUB 3 -> wraps to 0xFF.
    runCycles("LDA9", 4'h0, 8'd9, 6, EXP_LDA);
    runCycles("SUB4", 4'h2, 8'd4, 7, EXP_SUB);
    checkOutput("acc after SUB", 32'(accModel), 32'd5);
    runCycles("LDA2", 4'h0, 8'd2, 6, EXP_LDA);
    runCycles("SUB3", 4'h2, 8'd3, 7, EXP_SUB);
    checkOutput("acc after SUB wrap", 32'(accModel), 32'hFF);

    // OUT and an undefined opcode running as a NOP
    runCycles("OUT", 4'hE, 8'd0, 6, EXP_OUT);
    runCycles("NOP7", 4'h7, 8'd0, 6, EXP_NOP);
    checkOutput("acc after OUT/NOP", 32'(accModel), 32'hFF);

    // Reset in T5 of an ADD: back to IDLE with no accumulator load.
    runCycles("ADDrst", 4'h1, 8'd1, 4, EXP_ADD);
    checkOutput("ADDrst ctrl T5", 32'(ctrlObs), 32'(C_RAM_OE | C_B_LD));
    checkOutput("ADDrst tstate T5", 32'(tstate), 32'h10);
    applyStimulus(1'b1, 1'b0, 4'h1);
    checkOutput("midrst ctrl", 32'(ctrlObs), 32'(C_NONE));
    checkOutput("midrst tstate", 32'(tstate), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 4'h1);
      checkOutput("post-rst idle ctrl", 32'(ctrlObs), 32'(C_NONE));
      checkOutput("post-rst idle tstate", 32'(tstate), 32'd0);
    end
    checkOutput("acc after midrst", 32'(accModel), 32'hFF);

    // HLT: T1..T4, then HALT for 12 cycles regardless of run_i.
    applyStimulus(1'b0, 1'b1, 4'hF);
    runCycles("HLT", 4'hF, 8'd0, 4, EXP_NOP);
    for (int i = 0; i < 12; i++) begin
      checkOutput("halt ctrl", 32'(ctrlObs), 32'(C_HLT));
      checkOutput("halt tstate", 32'(tstate), 32'd0);
      applyStimulus(1'b0, i[0], 4'(i));
    end
    applyStimulus(1'b1, 1'b0, 4'hF);
    checkOutput("halt rst ctrl", 32'(ctrlObs), 32'(C_NONE));
    checkOutput("halt rst tstate", 32'(tstate), 32'd0);
    applyStimulus(1'b0, 1'b0, 4'hF);
    checkOutput("after halt idle ctrl", 32'(ctrlObs), 32'(C_NONE));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
